// File: rtl/cpu_pkg.sv
// Shared types and constants for the 5-stage ARM pipeline.
// Control bundle layout, zero register index and the NOP bundle.
package cpu_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       MemToReg;
        logic       ALUSrc;
        logic [2:0] ALUOp;
        logic       BrTaken;
        logic       UncondBr;
        logic       SetFlags;
        logic       Reg2Loc;
    } ctrl_t;

    localparam logic [4:0] XZR      = 5'd31;
    localparam ctrl_t      CTRL_NOP = '0;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux for one EX-stage source operand.
// XZR beats everything, then EX/MEM, then MEM/WB, then the stored value.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic [AW-1:0] i_idx,
    input  logic [DW-1:0] i_val,
    input  logic          i_ex_we,
    input  logic [AW-1:0] i_ex_rd,
    input  logic [DW-1:0] i_ex_val,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_rd,
    input  logic [DW-1:0] i_wb_val,
    output logic [DW-1:0] o_op
);

    logic w_zr;
    logic w_ex_hit;
    logic w_wb_hit;

    assign w_zr     = (i_idx == AW'(XZR));
    assign w_ex_hit = i_ex_we && (i_ex_rd == i_idx);
    assign w_wb_hit = i_wb_we && (i_wb_rd == i_idx);

    always_comb begin
        o_op = i_val;
        if (w_zr)
            o_op = '0;
        else if (w_ex_hit)
            o_op = i_ex_val;
        else if (w_wb_hit)
            o_op = i_wb_val;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass at capture, load-use
// hazard detection and EX-stage operand forwarding.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic [AW-1:0] id_rd,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  ctrl_t         id_ctrl,
    input  logic          flush,
    input  logic          exmem_regwrite,
    input  logic [AW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [AW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_wdata,
    output logic          stall,
    output logic          ex_valid,
    output ctrl_t         ex_ctrl,
    output logic [AW-1:0] ex_rd,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_opA,
    output logic [DW-1:0] ex_opB
);

    logic          r_valid;
    ctrl_t         r_ctrl;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_imm;
    logic [AW-1:0] r_rs1;
    logic [AW-1:0] r_rs2;
    logic [DW-1:0] r_op1;
    logic [DW-1:0] r_op2;

    logic [DW-1:0] w_cap1;
    logic [DW-1:0] w_cap2;
    logic          w_rd_hit;
    logic          w_bubble;

    // Register file writes on the edge, so a same-cycle read is stale.
    always_comb begin
        w_cap1 = id_rdata1;
        w_cap2 = id_rdata2;
        if (id_rs1 == AW'(XZR))
            w_cap1 = '0;
        else if (memwb_regwrite && memwb_rd == id_rs1)
            w_cap1 = memwb_wdata;
        if (id_rs2 == AW'(XZR))
            w_cap2 = '0;
        else if (memwb_regwrite && memwb_rd == id_rs2)
            w_cap2 = memwb_wdata;
    end

    assign w_rd_hit = (r_rd == id_rs1) || (r_rd == id_rs2);
    assign stall    = r_valid && r_ctrl.MemRead && (r_rd != AW'(XZR))
                    && w_rd_hit && id_valid;
    assign w_bubble = flush || stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
            r_rd    <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
        end else begin
            r_valid <= id_valid;
            r_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
            r_rd    <= id_rd;
            r_imm   <= id_imm;
            r_rs1   <= id_rs1;
            r_rs2   <= id_rs2;
            r_op1   <= w_cap1;
            r_op2   <= w_cap2;
        end
    end

    fwd_unit #(.DW(DW), .AW(AW)) u_fwd_a (
        .i_idx    (r_rs1),
        .i_val    (r_op1),
        .i_ex_we  (exmem_regwrite),
        .i_ex_rd  (exmem_rd),
        .i_ex_val (exmem_result),
        .i_wb_we  (memwb_regwrite),
        .i_wb_rd  (memwb_rd),
        .i_wb_val (memwb_wdata),
        .o_op     (ex_opA)
    );

    fwd_unit #(.DW(DW), .AW(AW)) u_fwd_b (
        .i_idx    (r_rs2),
        .i_val    (r_op2),
        .i_ex_we  (exmem_regwrite),
        .i_ex_rd  (exmem_rd),
        .i_ex_val (exmem_result),
        .i_wb_we  (memwb_regwrite),
        .i_wb_rd  (memwb_rd),
        .i_wb_val (memwb_wdata),
        .o_op     (ex_opB)
    );

    assign ex_valid = r_valid;
    assign ex_ctrl  = r_ctrl;
    assign ex_rd    = r_rd;
    assign ex_imm   = r_imm;

endmodule
